// File: rtl/butterfly_pkg.sv
// Shared types and defaults for the butterfly write-back block.
package butterfly_pkg;

  // Width of one crossbar output word and of the memory write data.
  localparam int DEFAULT_DATA_W = 128;

  // Stage sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One butterfly-pair result; word1 is written before word2.
  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] word1;
    logic [DEFAULT_DATA_W-1:0] word2;
  } pair_t;

endpackage

// File: rtl/butterfly_pair_fifo.sv
// Synchronous FIFO of butterfly pairs. Besides full, it exposes a
// look-ahead view of the head as it will be after the current edge, so the
// registered serialiser can present a freshly pushed pair one cycle later.
module butterfly_pair_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] word1_i,
  input  logic [DATA_W-1:0] word2_i,
  output logic              full_o,
  output logic              next_empty_o,
  output logic [DATA_W-1:0] next_word1_o,
  output logic [DATA_W-1:0] next_word2_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2*DATA_W-1:0] next_entry_s;

  // Next pointers/occupancy, and the entry that will sit at the head after this edge.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (count_q == CNT_W'(pop_i)) begin
      // Nothing left behind the popped head: the incoming pair becomes the head.
      next_entry_s = {word1_i, word2_i};
    end else begin
      next_entry_s = mem_q[rd_ptr_d];
    end
  end

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign next_empty_o = (count_d == {CNT_W{1'b0}});
  assign next_word1_o = next_entry_s[2*DATA_W-1 -: DATA_W];
  assign next_word2_o = next_entry_s[DATA_W-1:0];

  // Pair storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= {word1_i, word2_i};
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/butterfly_writeback.sv
// Buffers butterfly pairs from the output crossbar and serialises them onto
// one memory write port at sequential addresses, pulsing done per stage.
module butterfly_writeback
  import butterfly_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_START,
  input  logic [ADDR_W-1:0] i_BASE_ADDR,
  input  logic [ADDR_W-1:0] i_NUM_PAIRS,
  input  logic              i_VALID,
  output logic              o_READY,
  input  logic [DATA_W-1:0] i_READ_OUTPUT1,
  input  logic [DATA_W-1:0] i_READ_OUTPUT2,
  output logic              o_WR_EN,
  output logic [ADDR_W-1:0] o_WR_ADDR,
  output logic [DATA_W-1:0] o_WR_DATA,
  input  logic              i_WR_READY,
  output logic              o_BUSY,
  output logic              o_DONE
);

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W:0]   acc_cnt_q;
  logic [ADDR_W:0]   wr_cnt_q;
  logic              half_q, half_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              full_s, next_empty_s;
  logic [DATA_W-1:0] next_w1_s, next_w2_s;
  logic              ready_s, push_s, fire_s, pop_s, last_write_s;

  // Ready ignores a same-cycle pop so it depends only on flops.
  assign ready_s      = (state_q == ST_RUN) && !full_s && (acc_cnt_q < {1'b0, target_q});
  assign push_s       = i_VALID && ready_s;
  assign fire_s       = wr_en_q && i_WR_READY;
  assign pop_s        = fire_s && half_q;
  assign last_write_s = fire_s && ((wr_cnt_q + CNT_ONE) == {target_q, 1'b0});
  assign half_d       = half_q ^ fire_s;

  butterfly_pair_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i        (i_CLK),
    .rst_ni       (i_RST_N),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .word1_i      (i_READ_OUTPUT1),
    .word2_i      (i_READ_OUTPUT2),
    .full_o       (full_s),
    .next_empty_o (next_empty_s),
    .next_word1_o (next_w1_s),
    .next_word2_o (next_w2_s)
  );

  // Stage FSM with address, half-select and accept/write counters.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q   <= ST_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      target_q  <= {ADDR_W{1'b0}};
      acc_cnt_q <= {(ADDR_W+1){1'b0}};
      wr_cnt_q  <= {(ADDR_W+1){1'b0}};
      half_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_START) begin
            addr_q    <= i_BASE_ADDR;
            target_q  <= i_NUM_PAIRS;
            acc_cnt_q <= {(ADDR_W+1){1'b0}};
            wr_cnt_q  <= {(ADDR_W+1){1'b0}};
            half_q    <= 1'b0;
            state_q   <= (i_NUM_PAIRS == {ADDR_W{1'b0}}) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (push_s) begin
            acc_cnt_q <= acc_cnt_q + CNT_ONE;
          end
          if (fire_s) begin
            addr_q   <= addr_q + ADDR_ONE;
            half_q   <= half_d;
            wr_cnt_q <= wr_cnt_q + CNT_ONE;
          end
          if (last_write_s) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Next write request: hold while stalled, otherwise present the post-edge head half.
  always_comb begin
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    if (wr_en_q && !i_WR_READY) begin
      wr_en_d   = 1'b1;
      wr_data_d = wr_data_q;
    end else begin
      wr_en_d = (state_q == ST_RUN) && !next_empty_s;
      if (wr_en_d) begin
        wr_data_d = half_d ? next_w2_s : next_w1_s;
      end else begin
        wr_data_d = wr_data_q;
      end
    end
  end

  // Registered write-request outputs.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= {DATA_W{1'b0}};
    end else begin
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_READY   = ready_s;
  assign o_WR_EN   = wr_en_q;
  assign o_WR_ADDR = addr_q;
  assign o_WR_DATA = wr_data_q;
  assign o_BUSY    = (state_q != ST_IDLE);
  assign o_DONE    = (state_q == ST_DONE);

endmodule

// File: tb/tb_butterfly_writeback.sv
// Randomised bench for butterfly_writeback with a transaction-level model.
module tb_butterfly_writeback;
  import butterfly_pkg::*;

  localparam int DW    = 128;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] num = '0;
  logic          valid = 1'b0;
  logic [DW-1:0] w1 = '0;
  logic [DW-1:0] w2 = '0;
  logic          wr_ready = 1'b0;
  logic          o_ready, o_wr_en, o_busy, o_done;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;

  always #5 clk = ~clk;

  butterfly_writeback #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_START(start), .i_BASE_ADDR(base),
    .i_NUM_PAIRS(num), .i_VALID(valid), .o_READY(o_ready),
    .i_READ_OUTPUT1(w1), .i_READ_OUTPUT2(w2), .o_WR_EN(o_wr_en),
    .o_WR_ADDR(o_wr_addr), .o_WR_DATA(o_wr_data), .i_WR_READY(wr_ready),
    .o_BUSY(o_busy), .o_DONE(o_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int            m_phase = 0;   // 0 idle, 1 run, 2 done
  int            m_acc = 0, m_wr = 0, m_target = 0;
  int            m_base = 0;
  int            pending;
  bit            exp_ready, exp_en;
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  // Observed write log for hand-computed literal checks.
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int            done_cnt = 0;
  bit            ready_seen = 0, wr_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready", o_ready, 0);
      check("rst_wr_en", o_wr_en, 0);
      check("rst_wr_addr", o_wr_addr, 0);
      check("rst_wr_data", o_wr_data, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      m_phase = 0; m_acc = 0; m_wr = 0;
      q_addr.delete(); q_data.delete();
    end else begin
      pending   = 2 * m_acc - m_wr;
      exp_ready = (m_phase == 1) && ((m_acc - m_wr / 2) < DEPTH) && (m_acc < m_target);
      exp_en    = (m_phase == 1) && (pending > 0);
      check("busy", o_busy, (m_phase != 0));
      check("done", o_done, (m_phase == 2));
      check("ready", o_ready, exp_ready);
      check("wr_en", o_wr_en, exp_en);
      if (o_wr_en && exp_en) begin
        check("wr_addr", o_wr_addr, q_addr[0]);
        check("wr_data", o_wr_data, q_data[0]);
      end
      if (o_done) done_cnt++;
      if (o_ready) ready_seen = 1;
      if (o_wr_en) wr_seen = 1;
      if (o_wr_en && wr_ready) begin
        log_addr.push_back(o_wr_addr);
        log_data.push_back(o_wr_data);
      end
      if (exp_en && wr_ready) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        m_wr++;
      end
      if (exp_ready && valid) begin
        q_addr.push_back(AW'(m_base + 2 * m_acc));
        q_data.push_back(w1);
        q_addr.push_back(AW'(m_base + 2 * m_acc + 1));
        q_data.push_back(w2);
        m_acc++;
      end
      case (m_phase)
        0: if (start) begin
             m_base = int'(base); m_target = int'(num); m_acc = 0; m_wr = 0;
             m_phase = (num == 0) ? 2 : 1;
           end
        1: if (m_wr == 2 * m_target) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  pair_t pairs[$];

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic gen_pairs(input int n);
    pair_t p;
    pairs.delete();
    for (int i = 0; i < n; i++) begin
      p.word1 = rand_word();
      p.word2 = rand_word();
      pairs.push_back(p);
    end
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete();
    done_cnt = 0; ready_seen = 0; wr_seen = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    base = b; num = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Feed pairs[first..n-1] with random gaps and back-pressure until done.
  task automatic drive(input int first, input int n, input int vpct, input int rpct);
    int sent = first;
    int guard = 0;
    while (!o_done && guard < 3000) begin
      valid = (sent < n) && ($urandom_range(99) < vpct);
      if (sent < n) begin
        w1 = pairs[sent].word1;
        w2 = pairs[sent].word2;
      end
      wr_ready = ($urandom_range(99) < rpct);
      if (valid && o_ready) sent++;
      step();
      guard++;
    end
    valid = 1'b0;
    check("stage_done_seen", o_done, 1);
    step();
  endtask

  task automatic check_log_addrs(input string name, input logic [AW-1:0] first, input int n);
    check({name, "_len"}, log_addr.size(), n);
    for (int i = 0; i < n && i < log_addr.size(); i++)
      check({name, "_addr"}, log_addr[i], AW'(int'(first) + i));
  endtask

  task automatic check_log_data(input string name, input int n);
    for (int i = 0; i < n && 2 * i + 1 < log_data.size(); i++) begin
      check({name, "_w1"}, log_data[2*i], pairs[i].word1);
      check({name, "_w2"}, log_data[2*i+1], pairs[i].word2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;
  int            sent;
  int            guard;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Basic two-pair stage, back-to-back, memory always ready.
    clear_log(); gen_pairs(2);
    do_start(8'h10, 8'd2);
    drive(0, 2, 100, 100);
    check_log_addrs("basic", 8'h10, 4);
    check_log_data("basic", 2);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_idle", o_busy, 0);

    // Empty stage: done right after start, no handshake or writes.
    clear_log();
    do_start(8'h33, 8'd0);
    check("zero_done_next", o_done, 1);
    drive(0, 0, 100, 100);
    check("zero_ready_seen", ready_seen, 0);
    check("zero_wr_seen", wr_seen, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Back-pressure: memory stalled for 10 cycles while offering pairs every cycle.
    clear_log(); gen_pairs(4);
    do_start(8'h50, 8'd4);
    wr_ready = 1'b0; sent = 0;
    for (int i = 0; i < 10; i++) begin
      valid = (sent < 4);
      if (sent < 4) begin w1 = pairs[sent].word1; w2 = pairs[sent].word2; end
      if (valid && o_ready) sent++;
      step();
      if (i == 1) begin hold_addr = o_wr_addr; hold_data = o_wr_data; end
    end
    valid = 1'b0;
    check("stall_pushes", sent, 4);
    check("stall_ready_low", o_ready, 0);
    check("stall_addr_hold", o_wr_addr, hold_addr);
    check("stall_data_hold", o_wr_data, hold_data);
    check("stall_addr_lit", o_wr_addr, 8'h50);
    check("stall_data_lit", o_wr_data, pairs[0].word1);
    drive(4, 4, 100, 100);
    check_log_addrs("stall", 8'h50, 8);
    check_log_data("stall", 4);

    // Address wrap-around.
    clear_log(); gen_pairs(2);
    do_start(8'hFE, 8'd2);
    drive(0, 2, 100, 100);
    check("wrap_len", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check("wrap_a0", log_addr[0], 8'hFE);
      check("wrap_a1", log_addr[1], 8'hFF);
      check("wrap_a2", log_addr[2], 8'h00);
      check("wrap_a3", log_addr[3], 8'h01);
    end

    // Start during RUN is ignored.
    clear_log(); gen_pairs(3);
    do_start(8'h40, 8'd3);
    base = 8'h80; num = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    drive(0, 3, 70, 80);
    check_log_addrs("restart", 8'h40, 6);
    check_log_data("restart", 3);
    check("restart_done_cnt", done_cnt, 1);

    // Asynchronous reset mid-stage, then a clean new stage.
    clear_log(); gen_pairs(3);
    do_start(8'h20, 8'd3);
    wr_ready = 1'b1; sent = 0; guard = 0;
    while (log_addr.size() < 2 && guard < 50) begin
      valid = (sent < 3);
      if (sent < 3) begin w1 = pairs[sent].word1; w2 = pairs[sent].word2; end
      if (valid && o_ready) sent++;
      step();
      guard++;
    end
    check("midrst_two_writes", log_addr.size(), 2);
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    check("async_wr_en", o_wr_en, 0);
    check("async_wr_addr", o_wr_addr, 0);
    check("async_wr_data", o_wr_data, 0);
    check("async_busy", o_busy, 0);
    check("async_ready", o_ready, 0);
    check("async_done", o_done, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("post_rst_idle", o_busy, 0);
    clear_log(); gen_pairs(1);
    do_start(8'h30, 8'd1);
    drive(0, 1, 100, 100);
    check_log_addrs("post_rst", 8'h30, 2);
    check_log_data("post_rst", 1);

    // Randomised stages.
    for (int s = 0; s < 10; s++) begin
      int n;
      n = int'($urandom_range(1, 7));
      clear_log(); gen_pairs(n);
      do_start(AW'($urandom_range(255)), AW'(n));
      drive(0, n, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
      check("rand_len", log_addr.size(), 2 * n);
      check("rand_done_cnt", done_cnt, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
